// File: rtl/phase_frame_packer.sv
// Circular (wrap-aware) averaging of phase samples, packed into byte frames over valid/ready.
// Define PHASE_FRAME_CHK_EN to append an XOR check byte (SEQ ^ PH_HI ^ PH_LO) to each frame.
`timescale 1ns/1ps
module phase_frame_packer #(
  parameter int unsigned AVG_LOG2 = 3,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic       clk_60m,
  input  logic       rst_n,
  input  logic [8:0] phase_in,
  input  logic       phase_stb,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] frame_cnt,
  output logic [7:0] drop_cnt
);

  localparam int unsigned SW = 10 + AVG_LOG2;
  localparam int unsigned N  = 1 << AVG_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_PH_HI, S_PH_LO, S_CHK} state_t;

  state_t r_state, w_next;

  logic [6:0]          r_cnt;
  logic [8:0]          r_ref;
  logic signed [SW-1:0] r_sum;
  logic                r_cmp_vld;
  logic [8:0]          r_cmp_avg;
  logic                r_pending;
  logic [8:0]          r_pend_avg;
  logic                r_ovf;
  logic [8:0]          r_frm_avg;
  logic                r_frm_f;
  logic [7:0]          r_frame_cnt;
  logic [7:0]          r_drop_cnt;

  logic [8:0]           w_p, w_ref, w_avg;
  logic                 w_first, w_last, w_leave, w_fin;
  logic signed [10:0]   w_d_raw, w_d;
  logic signed [SW-1:0] w_d_ext, w_sum, w_shift;
  logic signed [11:0]   w_shift12, w_avg12;
  logic [7:0]           w_hi, w_lo;

  // First sample of a window becomes the reference, so its own delta is zero.
  always_comb begin
    w_p     = (phase_in >= 9'd360) ? '0 : phase_in;
    w_first = (r_cnt == '0);
    w_last  = (r_cnt == 7'(N - 1));
    w_ref   = w_first ? w_p : r_ref;
    w_d_raw = $signed({2'b00, w_p}) - $signed({2'b00, w_ref});
    w_d     = w_d_raw;
    if (w_d_raw >= 11'sd180)
      w_d = w_d_raw - 11'sd360;
    else if (w_d_raw < -11'sd180)
      w_d = w_d_raw + 11'sd360;
    w_d_ext   = SW'(w_d);
    w_sum     = (w_first ? '0 : r_sum) + w_d_ext;
    w_shift   = w_sum >>> AVG_LOG2;
    w_shift12 = 12'(w_shift);
    w_avg12   = $signed({3'b000, w_ref}) + w_shift12;
    if (w_avg12 < 12'sd0)
      w_avg12 = w_avg12 + 12'sd360;
    else if (w_avg12 >= 12'sd360)
      w_avg12 = w_avg12 - 12'sd360;
    w_avg = w_avg12[8:0];
  end

  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_ref     <= '0;
      r_sum     <= '0;
      r_cmp_vld <= 1'b0;
      r_cmp_avg <= '0;
    end else begin
      r_cmp_vld <= 1'b0;
      if (phase_stb) begin
        r_ref <= w_ref;
        r_sum <= w_sum;
        if (w_last) begin
          r_cnt     <= '0;
          r_cmp_vld <= 1'b1;
          r_cmp_avg <= w_avg;
        end else begin
          r_cnt <= r_cnt + 7'd1;
        end
      end
    end
  end

  assign w_leave = (r_state == S_IDLE) && r_pending;
`ifdef PHASE_FRAME_CHK_EN
  assign w_fin = tx_ready && (r_state == S_CHK);
`else
  assign w_fin = tx_ready && (r_state == S_PH_LO);
`endif

  // A completion coinciding with the FSM leaving IDLE takes the freed slot; later NBAs win.
  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= 1'b0;
      r_pend_avg  <= '0;
      r_ovf       <= 1'b0;
      r_frm_avg   <= '0;
      r_frm_f     <= 1'b0;
      r_drop_cnt  <= '0;
      r_frame_cnt <= '0;
      r_state     <= S_IDLE;
    end else begin
      r_state <= w_next;
      if (w_leave) begin
        r_frm_avg <= r_pend_avg;
        r_frm_f   <= r_ovf;
        r_ovf     <= 1'b0;
        r_pending <= 1'b0;
      end
      if (r_cmp_vld) begin
        if (!r_pending || w_leave) begin
          r_pending  <= 1'b1;
          r_pend_avg <= r_cmp_avg;
        end else begin
          r_ovf <= 1'b1;
          if (r_drop_cnt != '1)
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
      if (w_fin)
        r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign w_hi = {r_frm_f, 6'b000000, r_frm_avg[8]};
  assign w_lo = r_frm_avg[7:0];

  always_comb begin
    w_next   = r_state;
    tx_valid = 1'b1;
    tx_data  = '0;
    case (r_state)
      S_IDLE: begin
        tx_valid = 1'b0;
        if (r_pending) w_next = S_HDR;
      end
      S_HDR: begin
        tx_data = HEADER;
        if (tx_ready) w_next = S_SEQ;
      end
      S_SEQ: begin
        tx_data = r_frame_cnt;
        if (tx_ready) w_next = S_PH_HI;
      end
      S_PH_HI: begin
        tx_data = w_hi;
        if (tx_ready) w_next = S_PH_LO;
      end
      S_PH_LO: begin
        tx_data = w_lo;
`ifdef PHASE_FRAME_CHK_EN
        if (tx_ready) w_next = S_CHK;
`else
        if (tx_ready) w_next = S_IDLE;
`endif
      end
`ifdef PHASE_FRAME_CHK_EN
      S_CHK: begin
        tx_data = r_frame_cnt ^ w_hi ^ w_lo;
        if (tx_ready) w_next = S_IDLE;
      end
`endif
      default: begin
        tx_valid = 1'b0;
        w_next   = S_IDLE;
      end
    endcase
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule
